// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the wait-state memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_resp_state_t;

  localparam int WORD_BYTES = 4;

  // True when the byte address is word aligned and lands inside the array.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word storage: synchronous write and registered read on the same edge.
module mem_resp_array #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] r_mem [DEPTH];

  // Read returns the pre-write contents when a write hits the same word.
  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[index] <= wdata;
    end
    rdata <= r_mem[index];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with a fixed programmable wait-state latency,
// one outstanding transaction, and alignment/range error reporting.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam int OFF   = $clog2(WORD_BYTES);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  mem_resp_state_t  r_state;
  logic [3:0]       r_cnt;
  logic             r_write;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_rdSel;
  logic             r_reqReady;
  logic             r_respValid;
  logic             r_respErr;
  logic             r_busy;
  logic [CNT_W-1:0] r_txnCount;

  logic             w_addrOk;
  logic             w_commit;
  logic             w_we;
  logic [31:0]      w_arrRdata;

  assign w_addrOk = addr_ok(r_addr, 32'(DEPTH_WORDS));
  assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_we     = w_commit && r_write && w_addrOk;

  mem_resp_array #(
    .DEPTH(DEPTH_WORDS),
    .IDX_W(IDX_W)
  ) u_array (
    .clock(clock),
    .we   (w_we),
    .index(r_addr[IDX_W+OFF-1:OFF]),
    .wdata(r_wdata),
    .rdata(w_arrRdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rdSel     <= 1'b0;
      r_reqReady  <= 1'b1;
      r_respValid <= 1'b0;
      r_respErr   <= 1'b0;
      r_busy      <= 1'b0;
      r_txnCount  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_cnt      <= 4'(LATENCY - 1);
            r_rdSel    <= 1'b0;
            r_respErr  <= 1'b0;
            r_reqReady <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          // The array write and read both land on this same commit edge.
          if (r_cnt == 4'd0) begin
            r_respValid <= 1'b1;
            r_respErr   <= !w_addrOk;
            r_rdSel     <= w_addrOk && !r_write;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_respValid <= 1'b0;
            r_reqReady  <= 1'b1;
            r_busy      <= 1'b0;
            r_txnCount  <= r_txnCount + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_reqReady;
  assign resp_valid = r_respValid;
  assign resp_err   = r_respErr;
  assign busy       = r_busy;
  assign txn_count  = r_txnCount;
  assign resp_rdata = r_rdSel ? w_arrRdata : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases, latency/wrap sweep on
// small instances, and randomized traffic against a transaction-level model.
module tb_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_ready = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [15:0] txn_count;

  logic        lReqValid = 1'b0;
  logic        lReqWrite = 1'b0;
  logic [31:0] lReqAddr  = 32'd0;
  logic [31:0] lReqWdata = 32'd0;
  logic        fRespReady = 1'b0;
  logic        sRespReady = 1'b0;
  logic        fReqReady, fRespValid, fErr, fBusy;
  logic        sReqReady, sRespValid, sErr, sBusy;
  logic [31:0] fRdata, sRdata;
  logic [3:0]  fCount, sCount;

  int checks = 0;
  int errors = 0;
  bit cmpEn  = 1'b0;

  always #5 clock = ~clock;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .txn_count(txn_count)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .CNT_W(4)) u_fast (
    .clock(clock), .reset(reset),
    .req_valid(lReqValid), .req_ready(fReqReady), .req_write(lReqWrite),
    .req_addr(lReqAddr), .req_wdata(lReqWdata),
    .resp_valid(fRespValid), .resp_ready(fRespReady), .resp_rdata(fRdata),
    .resp_err(fErr), .busy(fBusy), .txn_count(fCount)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15), .CNT_W(4)) u_slow (
    .clock(clock), .reset(reset),
    .req_valid(lReqValid), .req_ready(sReqReady), .req_write(lReqWrite),
    .req_addr(lReqAddr), .req_wdata(lReqWdata),
    .resp_valid(sRespValid), .resp_ready(sRespReady), .resp_rdata(sRdata),
    .resp_err(sErr), .busy(sBusy), .txn_count(sCount)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: one pending request that matures LAT edges
  // after acceptance, then a response held until the CPU takes it.
  bit          mPend = 1'b0;
  bit          mValid = 1'b0;
  int          mLeft = 0;
  logic [15:0] mCount = 16'd0;
  logic        mWrite = 1'b0;
  logic [31:0] mAddr = 32'd0;
  logic [31:0] mWdata = 32'd0;
  logic [31:0] mRdata = 32'd0;
  logic        mErr = 1'b0;
  bit          mRdKnown = 1'b0;
  logic [31:0] mMem [DEPTH];
  bit          mKnown [DEPTH];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mPend  <= 1'b0;
      mValid <= 1'b0;
      mLeft  <= 0;
      mCount <= 16'd0;
    end else if (mValid) begin
      if (resp_ready) begin
        mValid <= 1'b0;
        mCount <= mCount + 16'd1;
      end
    end else if (mPend) begin
      if (mLeft == 1) begin
        mPend  <= 1'b0;
        mValid <= 1'b1;
        if ((mAddr % 4) != 0 || (mAddr / 4) >= DEPTH) begin
          mErr <= 1'b1; mRdata <= 32'd0; mRdKnown <= 1'b1;
        end else if (mWrite) begin
          mErr <= 1'b0; mRdata <= 32'd0; mRdKnown <= 1'b1;
          mMem[mAddr / 4]   <= mWdata;
          mKnown[mAddr / 4] <= 1'b1;
        end else begin
          mErr <= 1'b0;
          mRdata   <= mMem[mAddr / 4];
          mRdKnown <= mKnown[mAddr / 4];
        end
      end else begin
        mLeft <= mLeft - 1;
      end
    end else if (req_valid) begin
      mPend  <= 1'b1;
      mLeft  <= LAT;
      mWrite <= req_write;
      mAddr  <= req_addr;
      mWdata <= req_wdata;
    end
  end

  always @(negedge clock) begin
    if (cmpEn && !reset) begin
      checkOutput("req_ready", 32'(req_ready), 32'(!mPend && !mValid));
      checkOutput("busy", 32'(busy), 32'(mPend || mValid));
      checkOutput("resp_valid", 32'(resp_valid), 32'(mValid));
      checkOutput("txn_count", 32'(txn_count), 32'(mCount));
      if (mValid) begin
        checkOutput("resp_err", 32'(resp_err), 32'(mErr));
        if (mRdKnown) checkOutput("resp_rdata", resp_rdata, mRdata);
      end
    end
  end

  task automatic doTxn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, output logic [31:0] rdata, output logic err,
                       output int lat);
    int guard;
    @(negedge clock);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) checkOutput("accept timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (!resp_valid) checkOutput("response timeout", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0;
      @(negedge clock);
      checkOutput("held resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("held resp_rdata", resp_rdata, rdata);
      checkOutput("held resp_err", 32'(resp_err), 32'(err));
      checkOutput("held req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic smallTxn(input int i);
    int latF, latS;
    @(negedge clock);
    lReqValid = 1'b1; lReqWrite = 1'b1; lReqAddr = 32'(i * 4); lReqWdata = 32'(i);
    @(negedge clock);
    lReqValid = 1'b0;
    latF = -1;
    latS = -1;
    for (int c = 0; c <= 30; c++) begin
      if (latF < 0 && fRespValid) latF = c;
      if (latS < 0 && sRespValid) latS = c;
      if (latF >= 0 && latS >= 0) break;
      @(negedge clock);
    end
    checkOutput("fast latency", 32'(latF), 32'd1);
    checkOutput("slow latency", 32'(latS), 32'd15);
    fRespReady = 1'b1; sRespReady = 1'b1;
    @(negedge clock);
    fRespReady = 1'b0; sRespReady = 1'b0;
    checkOutput("fast txn_count", 32'(fCount), 32'((i + 1) % 16));
    checkOutput("slow txn_count", 32'(sCount), 32'((i + 1) % 16));
  endtask

  task automatic applyStimulus();
    int r;
    @(negedge clock);
    r = int'($urandom_range(0, 9));
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    if (r < 7)       req_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
    else if (r == 7) req_addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    else if (r == 8) req_addr = 32'(($urandom_range(0, 1000) + DEPTH) * 4);
    else             req_addr = $urandom;
    resp_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [15:0] cBefore;

    repeat (3) @(negedge clock);
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset txn_count", 32'(txn_count), 32'd0);
    checkOutput("reset fast count", 32'(fCount), 32'd0);
    reset = 1'b0;
    cmpEn = 1'b1;

    doTxn(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    checkOutput("write latency", 32'(lat), 32'd2);
    checkOutput("write err", 32'(er), 32'd0);
    checkOutput("write rdata", rd, 32'd0);
    doTxn(1'b0, 32'h10, 32'd0, 0, rd, er, lat);
    checkOutput("read 0x10", rd, 32'hDEADBEEF);
    checkOutput("count after two", 32'(txn_count), 32'd2);

    doTxn(1'b0, 32'h13, 32'd0, 0, rd, er, lat);
    checkOutput("misaligned read err", 32'(er), 32'd1);
    checkOutput("misaligned read rdata", rd, 32'd0);
    doTxn(1'b0, 32'h10, 32'd0, 0, rd, er, lat);
    checkOutput("read 0x10 again", rd, 32'hDEADBEEF);

    doTxn(1'b1, 32'hFC, 32'hA5A5A5A5, 0, rd, er, lat);
    doTxn(1'b1, 32'hFE, 32'h11111111, 0, rd, er, lat);
    checkOutput("misaligned write err", 32'(er), 32'd1);
    doTxn(1'b0, 32'hFC, 32'd0, 0, rd, er, lat);
    checkOutput("read 0xFC err", 32'(er), 32'd0);
    checkOutput("read 0xFC unchanged", rd, 32'hA5A5A5A5);
    doTxn(1'b0, 32'h100, 32'd0, 0, rd, er, lat);
    checkOutput("out of range err", 32'(er), 32'd1);

    cBefore = txn_count;
    doTxn(1'b0, 32'h10, 32'd0, 5, rd, er, lat);
    checkOutput("backpressure rdata", rd, 32'hDEADBEEF);
    checkOutput("backpressure count", 32'(txn_count), 32'(cBefore + 16'd1));
    doTxn(1'b0, 32'h10, 32'd0, 0, rd, er, lat);
    checkOutput("ignored write", rd, 32'hDEADBEEF);

    doTxn(1'b1, 32'h20, 32'hCAFEF00D, 0, rd, er, lat);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid-wait reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("mid-wait reset busy", 32'(busy), 32'd0);
    checkOutput("mid-wait reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("mid-wait reset resp_rdata", resp_rdata, 32'd0);
    checkOutput("mid-wait reset txn_count", 32'(txn_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    doTxn(1'b0, 32'h20, 32'd0, 0, rd, er, lat);
    checkOutput("dropped write", rd, 32'hCAFEF00D);

    for (int i = 0; i < 16; i++) smallTxn(i);

    for (int i = 0; i < DEPTH; i++) begin
      doTxn(1'b1, 32'(i * 4), $urandom, 0, rd, er, lat);
      checkOutput("preload err", 32'(er), 32'd0);
    end

    repeat (2000) applyStimulus();
    @(negedge clock);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (20) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
